// File: rtl/mmu_utlb.sv
// mmu_utlb: fully associative micro-TLB with a refill FSM to the main TLB.
//
// Optional feature macro: UTLB_ASID_TAG_EN
//   defined   -> each entry stores an ASID; entries match on VPN and (global or ASID).
//   undefined -> no ASID is stored; entries match on VPN alone, and any asid change
//                between consecutive cycles acts as a flush.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid, req_vaddr, asid  translation request and current ASID
//   flush                       invalidate all entries at the next edge
//   hit, paddr, uncached, dirty combinational lookup result (zero when no hit)
//   stall                       pipeline must hold the request
//   exp_miss, exp_invalid       one-cycle fault pulses (FSM in FAULT)
//   jtlb_req, jtlb_vaddr        refill request to the main TLB
//   jtlb_ack, jtlb_miss, jtlb_valid, jtlb_dirty, jtlb_uncached, jtlb_global, jtlb_pfn
//                               refill response, sampled only when jtlb_ack=1 in REFILL
module mmu_utlb #(
   parameter int unsigned ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_vaddr,
   input  logic [7:0]  asid,
   input  logic        flush,
   output logic        hit,
   output logic [31:0] paddr,
   output logic        uncached,
   output logic        dirty,
   output logic        stall,
   output logic        exp_miss,
   output logic        exp_invalid,
   output logic        jtlb_req,
   output logic [31:0] jtlb_vaddr,
   input  logic        jtlb_ack,
   input  logic        jtlb_miss,
   input  logic        jtlb_valid,
   input  logic        jtlb_dirty,
   input  logic        jtlb_uncached,
   input  logic        jtlb_global,
   input  logic [19:0] jtlb_pfn
);

   localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {StIdle, StRefill, StFault} state_e;

   state_e               state_q;
   logic [ENTRIES-1:0]   valid_q;
   logic [ENTRIES-1:0]   dirty_q;
   logic [ENTRIES-1:0]   unc_q;
   logic [19:0]          vpn_q [ENTRIES];
   logic [19:0]          pfn_q [ENTRIES];
   logic [IW-1:0]        rr_q;
   logic                 stale_q;

   logic [ENTRIES-1:0]   match;
   logic                 hit_any;
   logic [IW-1:0]        hit_idx;
   logic [IW-1:0]        victim;
   logic                 all_valid;
   logic                 fill;
   logic                 flush_eff;

`ifdef UTLB_ASID_TAG_EN
   logic [ENTRIES-1:0]   glob_q;
   logic [7:0]           asid_q [ENTRIES];

   assign flush_eff = flush;
`else
   logic [7:0]           asid_prev_q;
   logic                 unused_global;

   // Without per-entry ASID tags, a context switch must drop every translation.
   assign flush_eff     = flush | (asid != asid_prev_q);
   assign unused_global = jtlb_global;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) asid_prev_q <= '0;
      else     asid_prev_q <= asid;
   end
`endif

   always_comb begin
      match = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         match[i] = valid_q[i] && (vpn_q[i] == req_vaddr[31:12])
`ifdef UTLB_ASID_TAG_EN
                    && (glob_q[i] || (asid_q[i] == asid))
`endif
                    ;
      end
   end

   // Lowest matching index wins should a global and a private entry both match.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_any = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign hit      = req_valid & hit_any;
   assign paddr    = hit ? {pfn_q[hit_idx], req_vaddr[11:0]} : 32'h0;
   assign uncached = hit & unc_q[hit_idx];
   assign dirty    = hit & dirty_q[hit_idx];
   assign stall    = (req_valid && !hit && state_q == StIdle) || (state_q == StRefill);

   // Victim: lowest invalid entry, otherwise the round-robin pointer.
   always_comb begin
      victim    = rr_q;
      all_valid = &valid_q;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!valid_q[i]) victim = IW'(i);
      end
   end

   assign fill = (state_q == StRefill) && jtlb_ack && !stale_q && !jtlb_miss && jtlb_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         rr_q        <= '0;
         stale_q     <= 1'b0;
         jtlb_req    <= 1'b0;
         jtlb_vaddr  <= '0;
         exp_miss    <= 1'b0;
         exp_invalid <= 1'b0;
      end else begin
         exp_miss    <= 1'b0;
         exp_invalid <= 1'b0;
         if (fill) begin
            valid_q[victim] <= 1'b1;
            if (all_valid) rr_q <= (rr_q == IW'(ENTRIES - 1)) ? '0 : rr_q + 1'b1;
         end
         // Later assignment overrides the fill: flush wins.
         if (flush_eff) valid_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (req_valid && !hit) begin
                  jtlb_vaddr <= req_vaddr;
                  jtlb_req   <= 1'b1;
                  stale_q    <= 1'b0;
                  state_q    <= StRefill;
               end
            end
            StRefill: begin
               if (jtlb_ack) begin
                  jtlb_req <= 1'b0;
                  if (stale_q) begin
                     state_q <= StIdle;
                  end else if (jtlb_miss) begin
                     exp_miss <= 1'b1;
                     state_q  <= StFault;
                  end else if (!jtlb_valid) begin
                     exp_invalid <= 1'b1;
                     state_q     <= StFault;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (flush_eff) begin
                  stale_q <= 1'b1;
               end
            end
            StFault: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Entry payload needs no reset; it is qualified by valid_q.
   always_ff @(posedge clk) begin
      if (fill) begin
         vpn_q[victim]   <= jtlb_vaddr[31:12];
         pfn_q[victim]   <= jtlb_pfn;
         dirty_q[victim] <= jtlb_dirty;
         unc_q[victim]   <= jtlb_uncached;
`ifdef UTLB_ASID_TAG_EN
         glob_q[victim]  <= jtlb_global;
         asid_q[victim]  <= asid;
`endif
      end
   end

endmodule

// File: doc/mmu_utlb.md
MMU_UTLB -- requirements
Module: mmu_utlb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter ENTRIES, default 4, SHALL set the number of fully associative micro-TLB entries (legal values 2..16).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  translation request this cycle.
REQ-006 req_vaddr  in  32  virtual address (4 KB pages; VPN = [31:12]).
REQ-007 asid  in  8  current ASID.
REQ-008 flush  in  1  invalidate all entries (driven by tlbwi).
REQ-009 hit  out  1  request hit a valid entry.
REQ-010 paddr  out  32  {entry PFN, req_vaddr[11:0]}; 0 when hit=0.
REQ-011 uncached, dirty  out  1 each  attributes of the hit entry; 0 when hit=0.
REQ-012 stall  out  1  pipeline must hold the request.
REQ-013 exp_miss, exp_invalid  out  1 each  one-cycle fault pulses.
REQ-014 jtlb_req  out  1; jtlb_vaddr  out  32  refill request to the main TLB.
REQ-015 jtlb_ack  in  1; jtlb_miss, jtlb_valid, jtlb_dirty, jtlb_uncached, jtlb_global  in  1 each; jtlb_pfn  in  20  refill response, sampled only when jtlb_ack=1.

Function
REQ-016 An entry SHALL hit when valid=1, its VPN equals req_vaddr[31:12], and (global=1 or its ASID equals asid).
REQ-017 hit, paddr, uncached and dirty SHALL be combinational from req_vaddr in the same cycle (zero-cycle hit latency).
REQ-018 The FSM SHALL have states IDLE, REFILL, FAULT; it resets to IDLE.
REQ-019 IDLE: on req_valid=1 and hit=0, the FSM SHALL latch req_vaddr into jtlb_vaddr and go to REFILL next cycle.
REQ-020 stall SHALL equal (req_valid and not hit and state=IDLE) or state=REFILL; stall SHALL be 0 in FAULT.
REQ-021 REFILL: jtlb_req SHALL be held 1 until the cycle jtlb_ack=1; jtlb_vaddr SHALL remain stable throughout, even if req_vaddr changes.
REQ-022 On ack with jtlb_miss=0 and jtlb_valid=1, the block SHALL write {VPN, asid, pfn, dirty, uncached, global, valid=1} into the victim entry and return to IDLE; the retried request hits the next cycle.
REQ-023 On ack with jtlb_miss=1, the block SHALL go to FAULT with exp_miss=1 for that one cycle; on jtlb_miss=0 and jtlb_valid=0, it SHALL pulse exp_invalid likewise; no entry is written; FAULT returns to IDLE unconditionally.
REQ-024 Victim selection SHALL be the lowest-index invalid entry if one exists, else a round-robin pointer; the pointer SHALL advance only on a fill when all entries were valid and wrap ENTRIES-1 -> 0.
REQ-025 flush SHALL clear every valid bit at the next edge; a flush in the same cycle as a fill SHALL win (the entry is not retained).
REQ-026 A flush during REFILL SHALL mark the pending refill stale; on its ack the response SHALL be discarded (no fill, no fault) and the FSM SHALL return to IDLE to re-miss.
REQ-027 jtlb_ack seen outside REFILL SHALL be ignored.

Reset
REQ-028 On rst all valid bits, the round-robin pointer, jtlb_req, jtlb_vaddr and the stale flag SHALL be 0, and the FSM SHALL be in IDLE; all outputs SHALL read 0 apart from stall=req_valid.
REQ-029 rst asserted mid-REFILL SHALL abort the refill with no fill; a later ack SHALL be ignored.

Configuration
REQ-030 Macro UTLB_ASID_TAG_EN: when defined, entries SHALL store and compare ASID per REQ-016.
REQ-031 When UTLB_ASID_TAG_EN is undefined, no ASID SHALL be stored, every valid entry SHALL match on VPN alone, and any change of asid between consecutive cycles SHALL act as flush (REQ-025/026).

Verification
REQ-032 After reset, req 0x00401234 with empty uTLB -> stall=1, jtlb_req=1 with jtlb_vaddr=0x00401234; ack pfn=0x12345, valid=1 -> next cycle hit=1, paddr=0x12345234, stall=0.
REQ-033 ENTRIES=4: fill 5 distinct VPNs -> fifth fill replaces entry 0; re-access of the first VPN misses, the other three hit.
REQ-034 Refill ack with jtlb_miss=1 -> exp_miss=1 for exactly one cycle, stall=0 that cycle, no entry written; same with valid=0 -> exp_invalid pulse.
REQ-035 flush asserted while waiting in REFILL, ack 3 cycles later -> no fill, no fault, FSM back to IDLE and the request re-misses with jtlb_req=1.
REQ-036 With UTLB_ASID_TAG_EN, non-global entry under asid 0x05 then asid 0x06 -> miss; global entry -> hit; without the macro, the asid change invalidates all entries.
